reservation_station: RTL
========================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter: RS_SIZE, default 8, number of entries (power of two, at most 16).
REQ-002 Port: clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst_in  input  1  synchronous, active-high reset.
REQ-004 Port: rdy_in  input  1  global ready; when low, all state SHALL hold and ex_flag SHALL be 0.
REQ-005 Port: clr_in  input  1  misprediction flush.
REQ-006 Port: is_valid  input  1  issue request this cycle.
REQ-007 Port: is_op  input  6  opcode, same encoding as the ALU opcode.
REQ-008 Port: is_vj, is_vk  input  32 each  operand values, meaningful when the matching ready bit is 1.
REQ-009 Port: is_qj, is_qk  input  4 each  producer ROB tags, meaningful when the matching ready bit is 0.
REQ-010 Port: is_rj, is_rk  input  1 each  operand-ready flags.
REQ-011 Port: is_rob  input  4  destination ROB index.
REQ-012 Port: cdb_alu_valid/cdb_alu_rob/cdb_alu_val  input  1/4/32  ALU broadcast.
REQ-013 Port: cdb_lsb_valid/cdb_lsb_rob/cdb_lsb_val  input  1/4/32  load/store broadcast.
REQ-014 Port: ex_flag  output  1  dispatch valid to ALU.
REQ-015 Port: ex_op  output  6  dispatched opcode.
REQ-016 Port: ex_val1, ex_val2  output  32 each  dispatched operands.
REQ-017 Port: ex_rob  output  4  dispatched ROB index.
REQ-018 Port: rs_full  output  1  all entries busy.

Function
REQ-019 Each entry SHALL hold: busy, op, vj, vk, qj, qk, rj, rk, rob.
REQ-020 rs_full SHALL be combinational, equal to 1 exactly when all RS_SIZE busy bits are 1.
REQ-021 Issue: if is_valid, rdy_in, !clr_in and !rs_full, the lowest-index free entry SHALL be written and set busy at the edge; otherwise the issue SHALL be dropped.
REQ-022 Issue forwarding: an incoming operand with r=0 SHALL be captured as ready, with the CDB value, if its tag matches a valid CDB broadcast in the same cycle; the ALU broadcast SHALL have priority if both match.
REQ-023 Wakeup: every busy entry with rj=0 and qj equal to a valid CDB tag SHALL set rj=1 and vj to that value at the edge; k operands SHALL behave identically.
REQ-024 Dispatch: each cycle the lowest-index busy entry with rj=rk=1 (registered state) SHALL be selected; at the edge ex_* SHALL be loaded from it, ex_flag set to 1, and the entry freed.
REQ-025 With no ready entry, ex_flag SHALL be 0 and ex_op/ex_val1/ex_val2/ex_rob SHALL be 0.
REQ-026 Latency: issue with both operands ready SHALL dispatch at the earliest one edge after the issue edge; an operand woken at edge N SHALL make its entry eligible for dispatch at edge N+1.
REQ-027 ex_flag SHALL be a one-cycle pulse per dispatched entry; at most one dispatch per cycle.
REQ-028 Simultaneous issue and dispatch SHALL be allowed; full is evaluated on pre-edge state, so issue while full SHALL be dropped even if an entry frees that cycle.
REQ-029 clr_in (with rdy_in) SHALL clear all busy bits and ex_flag at the edge, overriding issue, wakeup and dispatch.

Reset
REQ-030 When rst_in is 1 at an edge, all busy/rj/rk bits SHALL be 0, ex_flag=0, ex_op=0, ex_val1=ex_val2=0, and ex_rob=0, regardless of rdy_in.
REQ-031 After reset rs_full SHALL read 0; reset mid-operation SHALL discard all entries without dispatch.

Verification
REQ-032 Issue ADD, vj=5, vk=7, rj=rk=1, rob=3 -> next cycle ex_flag=1, ex_op=ADD, ex_val1=5, ex_val2=7, ex_rob=3, then ex_flag=0.
REQ-033 Issue SUB with qj=2, rj=0; 3 cycles later cdb_lsb rob=2, val=0x10 -> dispatch one cycle after wakeup with ex_val1=0x10.
REQ-034 Issue with qk=4, rk=0 in the same cycle as cdb_alu rob=4, val=9 -> captured; dispatch next cycle with ex_val2=9.
REQ-035 Issue 8 non-ready entries -> rs_full=1; 9th issue dropped; wake one -> it dispatches, rs_full=0 after the edge.
REQ-036 Fill 3 entries, assert clr_in -> no dispatch, rs_full=0; assert rdy_in=0 with ready entries -> ex_flag stays 0, state held.

Source files
------------

// File: rtl/reservation_station.sv
// ============================================================================
// Module   : reservation_station
// Brief    : ALU reservation station with CDB wakeup/forwarding and
//            lowest-index-first dispatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reservation_station #(
    parameter int RS_SIZE = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clr_in,
    input  logic        is_valid,
    input  logic [5:0]  is_op,
    input  logic [31:0] is_vj,
    input  logic [31:0] is_vk,
    input  logic [3:0]  is_qj,
    input  logic [3:0]  is_qk,
    input  logic        is_rj,
    input  logic        is_rk,
    input  logic [3:0]  is_rob,
    input  logic        cdb_alu_valid,
    input  logic [3:0]  cdb_alu_rob,
    input  logic [31:0] cdb_alu_val,
    input  logic        cdb_lsb_valid,
    input  logic [3:0]  cdb_lsb_rob,
    input  logic [31:0] cdb_lsb_val,
    output logic        ex_flag,
    output logic [5:0]  ex_op,
    output logic [31:0] ex_val1,
    output logic [31:0] ex_val2,
    output logic [3:0]  ex_rob,
    output logic        rs_full
);

    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] rj_q, rj_d;
    logic [RS_SIZE-1:0] rk_q, rk_d;
    logic [5:0]         op_q  [RS_SIZE];
    logic [5:0]         op_d  [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vj_d  [RS_SIZE];
    logic [31:0]        vk_q  [RS_SIZE];
    logic [31:0]        vk_d  [RS_SIZE];
    logic [3:0]         qj_q  [RS_SIZE];
    logic [3:0]         qj_d  [RS_SIZE];
    logic [3:0]         qk_q  [RS_SIZE];
    logic [3:0]         qk_d  [RS_SIZE];
    logic [3:0]         rob_q [RS_SIZE];
    logic [3:0]         rob_d [RS_SIZE];

    logic        ex_flag_q;
    logic [5:0]  ex_op_q;
    logic [31:0] ex_val1_q;
    logic [31:0] ex_val2_q;
    logic [3:0]  ex_rob_q;

    logic          w_free_found;
    logic [IW-1:0] w_free_idx;
    logic          w_disp_found;
    logic [IW-1:0] w_disp_idx;
    logic          w_issue;
    logic          w_in_rj;
    logic          w_in_rk;
    logic [31:0]   w_in_vj;
    logic [31:0]   w_in_vk;

    assign rs_full = &busy_q;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_disp_found = 1'b0;
        w_disp_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(i);
            end
            if (busy_q[i] && rj_q[i] && rk_q[i]) begin
                w_disp_found = 1'b1;
                w_disp_idx   = IW'(i);
            end
        end
    end

    // Incoming operands may be satisfied by a same-cycle broadcast; ALU wins ties.
    always_comb begin
        w_in_rj = is_rj;
        w_in_vj = is_vj;
        if (!is_rj) begin
            if (cdb_alu_valid && cdb_alu_rob == is_qj) begin
                w_in_rj = 1'b1;
                w_in_vj = cdb_alu_val;
            end else if (cdb_lsb_valid && cdb_lsb_rob == is_qj) begin
                w_in_rj = 1'b1;
                w_in_vj = cdb_lsb_val;
            end
        end
        w_in_rk = is_rk;
        w_in_vk = is_vk;
        if (!is_rk) begin
            if (cdb_alu_valid && cdb_alu_rob == is_qk) begin
                w_in_rk = 1'b1;
                w_in_vk = cdb_alu_val;
            end else if (cdb_lsb_valid && cdb_lsb_rob == is_qk) begin
                w_in_rk = 1'b1;
                w_in_vk = cdb_lsb_val;
            end
        end
    end

    assign w_issue = is_valid && !rs_full && !clr_in && w_free_found;

    always_comb begin
        busy_d = busy_q;
        rj_d   = rj_q;
        rk_d   = rk_q;
        op_d   = op_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
        rob_d  = rob_q;

        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && !rj_q[i]) begin
                if (cdb_alu_valid && cdb_alu_rob == qj_q[i]) begin
                    rj_d[i] = 1'b1;
                    vj_d[i] = cdb_alu_val;
                end else if (cdb_lsb_valid && cdb_lsb_rob == qj_q[i]) begin
                    rj_d[i] = 1'b1;
                    vj_d[i] = cdb_lsb_val;
                end
            end
            if (busy_q[i] && !rk_q[i]) begin
                if (cdb_alu_valid && cdb_alu_rob == qk_q[i]) begin
                    rk_d[i] = 1'b1;
                    vk_d[i] = cdb_alu_val;
                end else if (cdb_lsb_valid && cdb_lsb_rob == qk_q[i]) begin
                    rk_d[i] = 1'b1;
                    vk_d[i] = cdb_lsb_val;
                end
            end
        end

        if (w_disp_found) begin
            busy_d[w_disp_idx] = 1'b0;
        end

        // The free slot is never the dispatching slot, so no conflict here.
        if (w_issue) begin
            busy_d[w_free_idx] = 1'b1;
            op_d[w_free_idx]   = is_op;
            vj_d[w_free_idx]   = w_in_vj;
            vk_d[w_free_idx]   = w_in_vk;
            qj_d[w_free_idx]   = is_qj;
            qk_d[w_free_idx]   = is_qk;
            rj_d[w_free_idx]   = w_in_rj;
            rk_d[w_free_idx]   = w_in_rk;
            rob_d[w_free_idx]  = is_rob;
        end

        if (clr_in) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            rj_q   <= '0;
            rk_q   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                rob_q[i] <= '0;
            end
            ex_flag_q <= 1'b0;
            ex_op_q   <= '0;
            ex_val1_q <= '0;
            ex_val2_q <= '0;
            ex_rob_q  <= '0;
        end else if (rdy_in) begin
            busy_q <= busy_d;
            rj_q   <= rj_d;
            rk_q   <= rk_d;
            op_q   <= op_d;
            vj_q   <= vj_d;
            vk_q   <= vk_d;
            qj_q   <= qj_d;
            qk_q   <= qk_d;
            rob_q  <= rob_d;
            if (clr_in || !w_disp_found) begin
                ex_flag_q <= 1'b0;
                ex_op_q   <= '0;
                ex_val1_q <= '0;
                ex_val2_q <= '0;
                ex_rob_q  <= '0;
            end else begin
                ex_flag_q <= 1'b1;
                ex_op_q   <= op_q[w_disp_idx];
                ex_val1_q <= vj_q[w_disp_idx];
                ex_val2_q <= vk_q[w_disp_idx];
                ex_rob_q  <= rob_q[w_disp_idx];
            end
        end else begin
            ex_flag_q <= 1'b0;
        end
    end

    assign ex_flag = ex_flag_q;
    assign ex_op   = ex_op_q;
    assign ex_val1 = ex_val1_q;
    assign ex_val2 = ex_val2_q;
    assign ex_rob  = ex_rob_q;

endmodule

`default_nettype wire
